// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/WB with internal regfile.
// Define MIPS_SHIFT_OPS_EN to enable SLL/SRL (R-type funct 0x00/0x02).
module mips_multicycle_core #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [31:0]     i_instr,
  input  logic            i_instr_valid,
  output logic            o_instr_ready,
  output logic            o_retire_valid,
  output logic            o_retire_illegal,
  output logic [4:0]      o_retire_dest,
  output logic [XLEN-1:0] o_retire_data,
  input  logic [4:0]      i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;
  logic [4:0]      r_dest;

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [IW-1:0]   w_rs_idx;
  logic [IW-1:0]   w_rt_idx;
  logic [IW-1:0]   w_wr_idx;
  logic [IW-1:0]   w_dbg_idx;
  logic [15:0]     w_imm;
  logic [XLEN-1:0] w_sext;
  logic [XLEN-1:0] w_zext;
  logic [XLEN-1:0] w_res;
  logic            w_ill;
  logic [4:0]      w_dst;
  logic            w_unused;

  assign w_op      = r_instr[31:26];
  assign w_funct   = r_instr[5:0];
  assign w_rt      = r_instr[20:16];
  assign w_rd      = r_instr[15:11];
  assign w_rs_idx  = r_instr[21 +: IW];
  assign w_rt_idx  = r_instr[16 +: IW];
  assign w_imm     = r_instr[15:0];
  assign w_sext    = XLEN'($signed(w_imm));
  assign w_zext    = XLEN'(w_imm);
  assign w_wr_idx  = r_dest[IW-1:0];
  assign w_dbg_idx = i_dbg_addr[IW-1:0];
  assign w_unused  = &{1'b0, i_dbg_addr, r_instr[25:21]};

`ifdef MIPS_SHIFT_OPS_EN
  logic [4:0] w_shamt;
  assign w_shamt = r_instr[10:6];
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  if (i_instr_valid) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Illegal encodings leave w_res at 0 so retire_data reads 0.
  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    w_dst = (w_op == 6'h00) ? w_rd : w_rt;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h20: w_res = r_a + r_b;
          6'h22: w_res = r_a - r_b;
          6'h24: w_res = r_a & r_b;
          6'h25: w_res = r_a | r_b;
          6'h2A: w_res = {{(XLEN-1){1'b0}},
                          ($signed(r_a) < $signed(r_b))};
`ifdef MIPS_SHIFT_OPS_EN
          6'h00: w_res = (32'(w_shamt) >= XLEN) ? '0 : (r_b << w_shamt);
          6'h02: w_res = (32'(w_shamt) >= XLEN) ? '0 : (r_b >> w_shamt);
`endif
          default: w_ill = 1'b1;
        endcase
      end
      6'h08:   w_res = r_a + w_sext;
      6'h0C:   w_res = r_a & w_zext;
      6'h0D:   w_res = r_a | w_zext;
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_instr   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_dest    <= '0;
    end else begin
      unique case (r_state)
        S_FETCH:  if (i_instr_valid) r_instr <= i_instr;
        S_DECODE: begin
          r_a <= (w_rs_idx == '0) ? '0 : r_regs[w_rs_idx];
          r_b <= (w_rt_idx == '0) ? '0 : r_regs[w_rt_idx];
        end
        S_EXEC: begin
          r_result  <= w_res;
          r_illegal <= w_ill;
          r_dest    <= w_dst;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_state == S_WB && !r_illegal && w_wr_idx != '0) begin
      r_regs[w_wr_idx] <= r_result;
    end
  end

  assign o_instr_ready    = (r_state == S_FETCH) && !i_reset;
  assign o_retire_valid   = (r_state == S_WB);
  assign o_retire_illegal = (r_state == S_WB) && r_illegal;
  assign o_retire_dest    = (r_state == S_WB) ? r_dest : 5'd0;
  assign o_retire_data    = (r_state == S_WB) ? r_result : '0;
  assign o_dbg_data       = (w_dbg_idx == '0) ? '0 : r_regs[w_dbg_idx];

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: random and directed instructions
// checked against an architectural register-file model.
module tb_mips_multicycle_core;

  localparam int XLEN = 32;
  localparam int NR   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     instr;
  logic            valid;
  logic            ready;
  logic            rv;
  logic            ril;
  logic [4:0]      rdst;
  logic [XLEN-1:0] rdat;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  mips_multicycle_core #(.XLEN(XLEN), .NUM_REGS(NR)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_instr          (instr),
    .i_instr_valid    (valid),
    .o_instr_ready    (ready),
    .o_retire_valid   (rv),
    .o_retire_illegal (ril),
    .o_retire_dest    (rdst),
    .o_retire_data    (rdat),
    .i_dbg_addr       (dbg_addr),
    .o_dbg_data       (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic            ill;
    logic [4:0]      dst;
    logic [XLEN-1:0] dat;
    int              cyc;
  } exp_t;

  exp_t            sbq[$];
  logic [XLEN-1:0] mdl [NR];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [XLEN-1:0] mread(input logic [4:0] a);
    int idx;
    idx = int'(a) % NR;
    return (idx == 0) ? '0 : mdl[idx];
  endfunction

  function automatic exp_t ref_model(input logic [31:0] ins);
    exp_t            e;
    logic [5:0]      op;
    logic [5:0]      fn;
    logic [4:0]      sh;
    logic [15:0]     imm;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    op  = ins[31:26];
    fn  = ins[5:0];
    sh  = ins[10:6];
    imm = ins[15:0];
    a   = mread(ins[25:21]);
    b   = mread(ins[20:16]);
    e.ill = 1'b0;
    e.dat = '0;
    e.cyc = 0;
    e.dst = (op == 6'h00) ? ins[15:11] : ins[20:16];
    if (op == 6'h00) begin
      case (fn)
        6'h20: e.dat = a + b;
        6'h22: e.dat = a - b;
        6'h24: e.dat = a & b;
        6'h25: e.dat = a | b;
        6'h2A: e.dat = ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef MIPS_SHIFT_OPS_EN
        6'h00: e.dat = (int'(sh) >= XLEN) ? 0 : b * (2 ** sh);
        6'h02: e.dat = (int'(sh) >= XLEN) ? 0 : b / (2 ** sh);
`endif
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08: e.dat = a + {{16{imm[15]}}, imm};
        6'h0C: e.dat = a & {16'h0, imm};
        6'h0D: e.dat = a | {16'h0, imm};
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) e.dat = '0;
    return e;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready, 1);
  endtask

  task automatic issue(input logic [31:0] ins);
    exp_t e;
    int   idx;
    wait_ready();
    dbg_addr = 5'($urandom);
    #1;
    chk("dbg_read", dbg_data, mread(dbg_addr));
    valid = 1'b1;
    instr = ins;
    @(posedge clk);
    #1;
    e     = ref_model(ins);
    e.cyc = cyc + 2;
    sbq.push_back(e);
    idx = int'(e.dst) % NR;
    if (!e.ill && idx != 0) mdl[idx] = e.dat;
    valid = 1'($urandom);
    instr = $urandom;
    @(posedge clk);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && rv) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL retire_unexpected: got dest %0d data %0h expected none",
                 rdst, rdat);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("retire_illegal", ril, e.ill);
        chk("retire_dest", rdst, e.dst);
        chk("retire_data", rdat, e.dat);
        chk("retire_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn;
    logic [5:0] op;
    int         k;
    k = $urandom_range(0, 9);
    if (k < 5) begin
      case ($urandom_range(0, 6))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h2A;
        5: fn = 6'h00;
        default: fn = 6'h02;
      endcase
      return {6'h00, 20'($urandom), fn};
    end else if (k < 9) begin
      case ($urandom_range(0, 3))
        0: op = 6'h08;
        1: op = 6'h0C;
        2: op = 6'h0D;
        default: op = 6'h08;
      endcase
      return {op, 26'($urandom)};
    end
    return $urandom;
  endfunction

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    rst      = 1'b1;
    valid    = 1'b0;
    instr    = '0;
    dbg_addr = 5'd1;
    #1;
    chk("reset_ready", ready, 0);
    chk("reset_retire", rv, 0);
    chk("reset_data", rdat, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", ready, 1);

    issue(32'h20010005);
    issue(32'h2002FFFF);
    issue(32'h0041182A);
    issue(32'h20000007);
    issue(32'hFC000000);
    wait_ready();
    dbg_addr = 5'd1; #1; chk("r1_is_5", dbg_data, 5);
    dbg_addr = 5'd2; #1; chk("r2_all_ones", dbg_data, 32'hFFFFFFFF);
    dbg_addr = 5'd3; #1; chk("r3_slt", dbg_data, 1);
    dbg_addr = 5'd0; #1; chk("r0_zero", dbg_data, 0);
    issue(32'h000128C0);
    wait_ready();
    dbg_addr = 5'd5;
    #1;
`ifdef MIPS_SHIFT_OPS_EN
    chk("sll_r5", dbg_data, 40);
`else
    chk("sll_r5_illegal", dbg_data, 0);
`endif

    wait_ready();
    valid = 1'b1;
    instr = 32'h20040009;
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("ready_in_reset", ready, 0);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_midreset", ready, 1);
    dbg_addr = 5'd4;
    #1 chk("r4_discarded", dbg_data, 0);
    dbg_addr = 5'd1;
    #1 chk("r1_cleared", dbg_data, 0);

    for (int i = 0; i < 250; i++) issue(rand_instr());

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
